// File: rtl/ifq_line_buffer.sv
// Instruction fetch queue: fetches whole lines from program memory into a circular line
// buffer and hands out one instruction per pop; redirects can enter a line mid-way.
module ifq_line_buffer #(
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned DEPTH_LINES = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        d_valid,
    input  logic [32*LINE_WORDS-1:0]                    mem_data,
    output logic                                        abort,
    output logic                                        m_rd_en,
    output logic [31:0]                                 mem_addr,
    input  logic                                        jump_branch_valid,
    input  logic [31:0]                                 jump_branch_add,
    input  logic                                        d_rd_en,
    output logic                                        empty,
    output logic [31:0]                                 i_code,
    output logic [31:0]                                 pc_out,
    output logic [$clog2(DEPTH_LINES*LINE_WORDS):0]     count
);

    localparam int unsigned LW_B = $clog2(LINE_WORDS);
    localparam int unsigned LP_W = $clog2(DEPTH_LINES) + 1;
    localparam int unsigned WP_W = $clog2(DEPTH_LINES * LINE_WORDS) + 1;
    localparam logic [31:0] LINE_BYTES = 32'(4 * LINE_WORDS);
    localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StAbort = 2'd2;

    logic [LP_W-1:0]  wr_lp_q, wr_lp_d;
    logic [WP_W-1:0]  rd_wp_q, rd_wp_d;
    logic [31:0]      pc_head_q, pc_head_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [1:0]       state_q, state_d;
    logic             line_we;

    logic [31:0]      line_q [DEPTH_LINES][LINE_WORDS];

    logic [LP_W-1:0]  rd_lp;
    logic [LP_W-1:0]  lines_used;
    logic [LP_W-2:0]  wr_idx;
    logic [LP_W-2:0]  rd_line;
    logic [LW_B-1:0]  rd_word;
    logic             pop;

    assign rd_lp      = rd_wp_q[WP_W-1:LW_B];
    assign lines_used = wr_lp_q - rd_lp;
    assign wr_idx     = wr_lp_q[LP_W-2:0];
    assign rd_line    = rd_wp_q[WP_W-2:LW_B];
    assign rd_word    = rd_wp_q[LW_B-1:0];

    assign empty    = (rd_lp == wr_lp_q);
    assign count    = empty ? '0 : ({wr_lp_q, {LW_B{1'b0}}} - rd_wp_q);
    assign i_code   = empty ? '0 : line_q[rd_line][rd_word];
    assign pc_out   = pc_head_q;
    assign mem_addr = fetch_addr_q;
    assign m_rd_en  = (state_q == StWait);
    assign abort    = (state_q == StAbort);
    assign pop      = d_rd_en & ~empty;

    always_comb begin
        wr_lp_d      = wr_lp_q;
        rd_wp_d      = rd_wp_q;
        pc_head_d    = pc_head_q;
        fetch_addr_d = fetch_addr_q;
        state_d      = state_q;
        line_we      = 1'b0;

        if (jump_branch_valid) begin
            // Redirect flushes everything; an in-flight read must be cancelled via abort.
            wr_lp_d      = '0;
            rd_wp_d      = WP_W'(jump_branch_add[LW_B+1:2]);
            pc_head_d    = jump_branch_add;
            fetch_addr_d = jump_branch_add & LINE_MASK;
            state_d      = (state_q == StWait) ? StAbort : StWait;
        end else begin
            if (pop) begin
                rd_wp_d   = rd_wp_q + WP_W'(1);
                pc_head_d = pc_head_q + 32'd4;
            end
            case (state_q)
                StIdle: begin
                    if (lines_used < LP_W'(DEPTH_LINES)) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (d_valid) begin
                        line_we      = 1'b1;
                        wr_lp_d      = wr_lp_q + LP_W'(1);
                        fetch_addr_d = fetch_addr_q + LINE_BYTES;
                        state_d      = (lines_used + LP_W'(1) < LP_W'(DEPTH_LINES)) ? StWait
                                                                                    : StIdle;
                    end
                end
                StAbort: state_d = StWait;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_lp_q      <= '0;
            rd_wp_q      <= WP_W'(RESET_PC[LW_B+1:2]);
            pc_head_q    <= RESET_PC;
            fetch_addr_q <= RESET_PC & LINE_MASK;
            state_q      <= StIdle;
        end else begin
            wr_lp_q      <= wr_lp_d;
            rd_wp_q      <= rd_wp_d;
            pc_head_q    <= pc_head_d;
            fetch_addr_q <= fetch_addr_d;
            state_q      <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                line_q[wr_idx][w] <= mem_data[32*w +: 32];
            end
        end
    end

endmodule

// File: tb/tb_ifq_line_buffer.sv
// Bench for ifq_line_buffer: scoreboard of expected (pc, instruction) pairs pushed at line
// delivery, plus a table of redirect scenarios and hand-written fill/wrap/reset sequences.
module tb_ifq_line_buffer;

    localparam int unsigned LW       = 4;
    localparam int unsigned DL       = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              rst;
    logic              d_valid;
    logic [32*LW-1:0]  mem_data;
    logic              abort;
    logic              m_rd_en;
    logic [31:0]       mem_addr;
    logic              jump_branch_valid;
    logic [31:0]       jump_branch_add;
    logic              d_rd_en;
    logic              empty;
    logic [31:0]       i_code;
    logic [31:0]       pc_out;
    logic [4:0]        count;

    ifq_line_buffer #(
        .LINE_WORDS (LW),
        .DEPTH_LINES(DL),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .d_valid          (d_valid),
        .mem_data         (mem_data),
        .abort            (abort),
        .m_rd_en          (m_rd_en),
        .mem_addr         (mem_addr),
        .jump_branch_valid(jump_branch_valid),
        .jump_branch_add  (jump_branch_add),
        .d_rd_en          (d_rd_en),
        .empty            (empty),
        .i_code           (i_code),
        .pc_out           (pc_out),
        .count            (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } sb_t;

    typedef struct {
        logic [31:0] target;
        bit          from_wait;
        logic [31:0] line;
        int          cnt;
    } redir_t;

    sb_t         sb[$];
    logic [31:0] sb_start;
    logic [31:0] exp_fetch;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A3C, ~pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock: optionally deliver the line for exp_fetch and/or pop one instruction.
    task automatic cycle(input bit dv, input bit do_pop);
        sb_t e;
        if (do_pop) begin
            chk("pop_empty", 32'(empty), 32'd0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("i_code", i_code, e.ins);
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_underrun: got pop, want no pending words");
            end
        end
        if (dv) begin
            chk("m_rd_en", 32'(m_rd_en), 32'd1);
            chk("mem_addr", mem_addr, exp_fetch);
            for (int w = 0; w < LW; w++) begin
                mem_data[32*w +: 32] = word_at(exp_fetch + 32'(4*w));
                if (exp_fetch + 32'(4*w) >= sb_start) begin
                    e.pc  = exp_fetch + 32'(4*w);
                    e.ins = word_at(e.pc);
                    sb.push_back(e);
                end
            end
            d_valid   = 1'b1;
            exp_fetch = exp_fetch + 32'(4*LW);
        end
        d_rd_en = do_pop;
        step();
        d_valid = 1'b0;
        d_rd_en = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target, input bit junk_dv);
        jump_branch_valid = 1'b1;
        jump_branch_add   = target;
        d_valid           = junk_dv;
        mem_data          = {LW{32'hBAD0_BAD0}};
        step();
        jump_branch_valid = 1'b0;
        d_valid           = 1'b0;
        sb.delete();
        sb_start  = target;
        exp_fetch = target & ~32'(4*LW - 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_m_rd_en", 32'(m_rd_en), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h100);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_i_code", i_code, 32'd0);
        chk("rst_pc_out", pc_out, 32'h100);
        chk("rst_count", 32'(count), 32'd0);
    endtask

    redir_t tbl[5];

    initial begin
        int nreq;
        tbl[0] = '{target: 32'h208, from_wait: 1'b1, line: 32'h200, cnt: 2};
        tbl[1] = '{target: 32'h20C, from_wait: 1'b0, line: 32'h200, cnt: 1};
        tbl[2] = '{target: 32'h134, from_wait: 1'b1, line: 32'h130, cnt: 3};
        tbl[3] = '{target: 32'h3F0, from_wait: 1'b0, line: 32'h3F0, cnt: 4};
        tbl[4] = '{target: 32'h004, from_wait: 1'b1, line: 32'h000, cnt: 3};

        rst = 1'b0; d_valid = 1'b0; mem_data = '0; jump_branch_valid = 1'b0;
        jump_branch_add = '0; d_rd_en = 1'b0;
        sb_start = RESET_PC; exp_fetch = RESET_PC;
        step();
        step();
        check_reset_outputs();
        rst = 1'b1;
        chk("cycle0_m_rd_en", 32'(m_rd_en), 32'd0);
        step();

        // Single line out of reset, popped word by word.
        cycle(1'b1, 1'b0);
        chk("fill1_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        chk("drained_empty", 32'(empty), 32'd1);
        d_rd_en = 1'b1;
        step();
        d_rd_en = 1'b0;
        chk("pop_while_empty_pc", pc_out, 32'h110);
        chk("pop_while_empty_cnt", 32'(count), 32'd0);

        // Reset mid-WAIT takes effect without a clock edge.
        chk("pre_reset_m_rd_en", 32'(m_rd_en), 32'd1);
        #3 rst = 1'b0;
        #1 check_reset_outputs();
        step();
        rst = 1'b1;
        sb.delete(); sb_start = RESET_PC; exp_fetch = RESET_PC;
        step();

        // Fill with no pops: exactly DL requests, then idle.
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_rd_en) begin
                cycle(1'b1, 1'b0);
                nreq++;
            end else begin
                step();
            end
        end
        chk("full_requests", 32'(nreq), 32'd4);
        chk("full_count", 32'(count), 32'd16);
        chk("full_m_rd_en", 32'(m_rd_en), 32'd0);
        cycle(1'b0, 1'b1);
        step();
        chk("one_pop_no_req", 32'(m_rd_en), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 5 && !m_rd_en; i++) step();
        chk("refetch_m_rd_en", 32'(m_rd_en), 32'd1);
        chk("refetch_addr", mem_addr, 32'h140);

        // Redirect scenarios.
        for (int t = 0; t < 5; t++) begin
            if (!tbl[t].from_wait) begin
                for (int i = 0; i < 10; i++) begin
                    if (m_rd_en) cycle(1'b1, 1'b0);
                    else step();
                end
                chk("pre_idle_m_rd_en", 32'(m_rd_en), 32'd0);
            end else begin
                for (int i = 0; i < 5 && !m_rd_en; i++) step();
                chk("pre_wait_m_rd_en", 32'(m_rd_en), 32'd1);
            end
            do_redirect(tbl[t].target, tbl[t].from_wait);
            chk("redir_abort", 32'(abort), 32'(tbl[t].from_wait));
            chk("redir_m_rd_en", 32'(m_rd_en), 32'(!tbl[t].from_wait));
            chk("redir_empty", 32'(empty), 32'd1);
            chk("redir_pc_out", pc_out, tbl[t].target);
            if (tbl[t].from_wait) begin
                d_valid  = 1'b1;
                mem_data = {LW{32'hDEAD_0000}};
                step();
                d_valid = 1'b0;
                chk("abort_pulse_end", 32'(abort), 32'd0);
                chk("late_dv_ignored", 32'(empty), 32'd1);
            end
            chk("redir_line", mem_addr, tbl[t].line);
            cycle(1'b1, 1'b0);
            chk("redir_count", 32'(count), 32'(tbl[t].cnt));
            for (int i = 0; i < tbl[t].cnt; i++) cycle(1'b0, 1'b1);
            chk("redir_drained", 32'(empty), 32'd1);
        end

        // Steady push+pop at count=4, wrapping pointers several times.
        for (int i = 0; i < 5 && !m_rd_en; i++) step();
        do_redirect(32'h500, 1'b0);
        step();
        cycle(1'b1, 1'b0);
        chk("wrap_start_count", 32'(count), 32'd4);
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 4; k++) cycle(k == 0, 1'b1);
            chk("wrap_count", 32'(count), 32'd4);
        end

        // Redirect again during the abort cycle: latest target wins, single abort pulse.
        do_redirect(32'h600, 1'b0);
        chk("dbl_abort", 32'(abort), 32'd1);
        do_redirect(32'h718, 1'b0);
        chk("dbl_abort_single", 32'(abort), 32'd0);
        cycle(1'b1, 1'b0);
        chk("dbl_count", 32'(count), 32'd2);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("dbl_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
